// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: data widths, reset
// vector, fetch FSM state encoding and the sequential pc increment.
package instr_fetch_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;

   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
   localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3,
      DRAIN = 3'd4
   } fetch_state_e;

   // Sequential fetch address; wraps modulo 2^XLEN.
   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/instr_fetch_out_reg.sv
// fetch_out_reg: output register toward decode.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_load           capture i_instruction/i_pc and raise o_valid
//   i_clear          drop o_valid (wins over i_load)
//   i_instruction    instruction word to capture
//   i_pc             address the word came from
//   o_valid, o_instruction, o_pc  registered decode-side outputs
module fetch_out_reg
   import instr_fetch_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_load,
   input  logic            i_clear,
   input  logic [ILEN-1:0] i_instruction,
   input  logic [XLEN-1:0] i_pc,
   output logic            o_valid,
   output logic [ILEN-1:0] o_instruction,
   output logic [XLEN-1:0] o_pc
);

   logic            r_valid;
   logic [ILEN-1:0] r_instruction;
   logic [XLEN-1:0] r_pc;

   // Payload is only written on load, so it holds while decode stalls.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid       <= 1'b0;
         r_instruction <= '0;
         r_pc          <= '0;
      end else if (i_clear) begin
         r_valid       <= 1'b0;
      end else if (i_load) begin
         r_valid       <= 1'b1;
         r_instruction <= i_instruction;
         r_pc          <= i_pc;
      end
   end

   assign o_valid       = r_valid;
   assign o_instruction = r_instruction;
   assign o_pc          = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit.
// Issues one request per instruction, waits for the response, hands the
// word to decode and waits for acceptance before fetching the next one.
// Redirects override everything; a redirect with a response still in
// flight goes through DRAIN to throw that response away.
// Ports:
//   i_clk, i_rst_n                     clock, async active-low reset
//   o_imem_req/o_imem_addr             fetch request and word address
//   i_imem_gnt/i_imem_rvalid/i_imem_rdata  memory handshake and data
//   i_redirect/i_redirect_pc           branch/jal pc redirect
//   o_valid/o_instruction/o_pc/i_ready decode handshake
//   o_misaligned                       (FETCH_ALIGN_CHECK_EN only) halted on
//                                      a misaligned redirect target
// Build option: define FETCH_ALIGN_CHECK_EN to enable misaligned-target
// detection; otherwise target bits [1:0] are ignored.
module instr_fetch
   import instr_fetch_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_rst_n,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_gnt,
   input  logic            i_imem_rvalid,
   input  logic [ILEN-1:0] i_imem_rdata,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic            o_misaligned,
`endif
   output logic            o_valid,
   output logic [ILEN-1:0] o_instruction,
   output logic [XLEN-1:0] o_pc,
   input  logic            i_ready
);

   fetch_state_e    r_state;
   logic [XLEN-1:0] r_pc;
   logic            w_load;
   logic            w_clear;
   logic            w_bad_target;
   logic            w_halted;
   logic            w_halt_next;
   fetch_state_e    w_resume;

`ifdef FETCH_ALIGN_CHECK_EN
   logic r_misaligned;

   assign w_bad_target = (i_redirect_pc[1:0] != 2'b00);

   // Flag follows the alignment of the most recent redirect target.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_misaligned <= 1'b0;
      end else if (i_redirect) begin
         r_misaligned <= w_bad_target;
      end
   end

   assign w_halted     = r_misaligned;
   assign o_misaligned = r_misaligned;
`else
   logic w_unused_pc_lsb;

   assign w_unused_pc_lsb = ^i_redirect_pc[1:0];
   assign w_bad_target    = 1'b0;
   assign w_halted        = 1'b0;
`endif

   // Where to go once no response is pending: park in IDLE while halted.
   assign w_halt_next = i_redirect ? w_bad_target : w_halted;
   assign w_resume    = w_halt_next ? IDLE : REQ;

   assign w_load  = (r_state == WAIT) && i_imem_rvalid && !i_redirect;
   assign w_clear = i_redirect || ((r_state == HOLD) && i_ready);

   // Fetch FSM and pc; redirect has priority over every handshake.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_pc    <= RESET_PC;
      end else begin
         if (i_redirect) begin
            r_pc <= {i_redirect_pc[XLEN-1:2], 2'b00};
         end else if (w_load) begin
            r_pc <= next_pc(r_pc);
         end

         unique case (r_state)
            IDLE: r_state <= w_resume;
            REQ: begin
               if (i_redirect) begin
                  r_state <= i_imem_gnt ? DRAIN : w_resume;
               end else if (i_imem_gnt) begin
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (i_redirect) begin
                  r_state <= i_imem_rvalid ? w_resume : DRAIN;
               end else if (i_imem_rvalid) begin
                  r_state <= HOLD;
               end
            end
            HOLD: begin
               if (i_redirect || i_ready) begin
                  r_state <= w_resume;
               end
            end
            DRAIN: begin
               if (i_imem_rvalid) begin
                  r_state <= w_resume;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_imem_req  = (r_state == REQ);
   assign o_imem_addr = r_pc;

   fetch_out_reg u_out_reg (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_load        (w_load),
      .i_clear       (w_clear),
      .i_instruction (i_imem_rdata),
      .i_pc          (r_pc),
      .o_valid       (o_valid),
      .o_instruction (o_instruction),
      .o_pc          (o_pc)
   );

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 o_imem_req  output  1  fetch request to instruction memory.
REQ-005 o_imem_addr  output  32  word address of the request, pc value.
REQ-006 i_imem_gnt  input  1  request accepted this cycle.
REQ-007 i_imem_rvalid  input  1  read data valid for the single outstanding request.
REQ-008 i_imem_rdata  input  32  fetched instruction word.
REQ-009 i_redirect  input  1  pc redirect from branch/jal resolution (pc + sign-extended immediate).
REQ-010 i_redirect_pc  input  32  redirect target.
REQ-011 o_valid  output  1  o_instruction/o_pc valid toward decode/immediate generation.
REQ-012 o_instruction  output  32  fetched instruction.
REQ-013 o_pc  output  32  address the instruction came from.
REQ-014 i_ready  input  1  decode accepts the instruction when o_valid & i_ready.

Function
REQ-015 States SHALL be IDLE, REQ, WAIT, HOLD, DRAIN; all outputs registered or decoded from state only.
REQ-016 IDLE SHALL go to REQ one cycle after reset release, pc = RESET_PC.
REQ-017 REQ SHALL drive o_imem_req=1, o_imem_addr=pc, both stable until i_imem_gnt; on gnt go to WAIT.
REQ-018 At most one request SHALL be outstanding; o_imem_req=0 in every state except REQ.
REQ-019 WAIT with i_imem_rvalid SHALL latch o_instruction=i_imem_rdata, o_pc=pc, set o_valid next cycle, pc<=pc+4, go to HOLD.
REQ-020 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-021 HOLD SHALL keep o_valid, o_instruction, o_pc stable until i_ready; on i_ready clear o_valid next cycle, go to REQ.
REQ-022 Zero-wait memory (gnt in REQ cycle, rvalid next cycle) SHALL give one instruction per 3 cycles.
REQ-023 i_redirect SHALL take priority over i_ready, gnt and rvalid in every state: pc<=i_redirect_pc, o_valid<=0 next cycle.
REQ-024 Redirect target state: REQ from IDLE/HOLD/REQ-without-gnt/WAIT-with-rvalid (response dropped); DRAIN from REQ-with-gnt or WAIT-without-rvalid.
REQ-025 DRAIN SHALL discard the next i_imem_rvalid response and then go to REQ; a further redirect in DRAIN updates pc only.
REQ-026 i_imem_rvalid outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-027 i_rst_n low SHALL immediately force state=IDLE, pc=RESET_PC, o_valid=0, o_imem_req=0, o_instruction=0, o_pc=0.
REQ-028 Reset mid-transaction SHALL abandon the outstanding request; no response may be consumed until a new grant.

Configuration
REQ-029 Macro FETCH_ALIGN_CHECK_EN defined: extra output o_misaligned (1 bit, reset 0); redirect with i_redirect_pc[1:0]!=0 sets it, fetch halts in IDLE (no requests) until an aligned redirect clears it and resumes in REQ.
REQ-030 Macro undefined: no o_misaligned port; i_redirect_pc[1:0] ignored, pc[1:0] always 00.

Structure
REQ-031 Shared package SHALL hold the fetch state enum, RESET_PC default, XLEN=32 and instruction-width constants.
REQ-032 One sub-module, fetch_out_reg, SHALL hold o_valid/o_instruction/o_pc with load/clear/hold controls.

Verification
REQ-033 Reset release, zero-wait memory returning 32'h00500093 at 0 -> o_valid cycle 3, o_pc=0, next o_imem_addr=4.
REQ-034 i_ready low 5 cycles in HOLD -> outputs stable, o_imem_req=0 throughout, REQ follows ready.
REQ-035 Redirect to 32'h0000_0100 in WAIT before rvalid -> DRAIN, stale rdata dropped, next addr 32'h100, no o_valid for stale word.
REQ-036 Redirect and i_ready same cycle in HOLD -> instruction not re-presented, next addr = target.
REQ-037 pc=32'hFFFF_FFFC fetch completes -> next o_imem_addr=32'h0.
REQ-038 FETCH_ALIGN_CHECK_EN: redirect to 32'h102 -> o_misaligned=1, no requests; redirect to 32'h104 -> flag clears, fetch at 32'h104.
